// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped one-word-per-line instruction cache between IF and Mem_ctrl
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   if_read_flag/if_read_address      instruction request from IF
//   flush                             invalidate all lines
//   _instruction_flag/_read_address/_instruction   one-cycle response to IF
//   _busy                             miss outstanding
//   mem_read_flag/mem_read_address    word read request to Mem_ctrl, held until fill
//   mem_instruction_flag/_read_address/mem_instruction   fill from Mem_ctrl
module icache_direct #(
    parameter int INDEX_BITS = 6,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_read_flag,
    input  logic [ADDR_WIDTH-1:0] if_read_address,
    input  logic                  flush,
    output logic                  _instruction_flag,
    output logic [ADDR_WIDTH-1:0] _instruction_read_address,
    output logic [31:0]           _instruction,
    output logic                  _busy,
    output logic                  mem_read_flag,
    output logic [ADDR_WIDTH-1:0] mem_read_address,
    input  logic                  mem_instruction_flag,
    input  logic [ADDR_WIDTH-1:0] mem_instruction_read_address,
    input  logic [31:0]           mem_instruction
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] MISS = 1'b1;

    logic [0:0]          state;
    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];
    logic                drop;

    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_BITS-1:0]   req_tag;
    logic [INDEX_BITS-1:0] pend_idx;
    logic [TAG_BITS-1:0]   pend_tag;
    logic                  hit;
    logic                  fill_match;
    logic                  install;
    logic [1:0]            unused_fill_lsbs;

    assign req_idx  = if_read_address[INDEX_BITS+1:2];
    assign req_tag  = if_read_address[ADDR_WIDTH-1:INDEX_BITS+2];
    // mem_read_address doubles as the pending miss address.
    assign pend_idx = mem_read_address[INDEX_BITS+1:2];
    assign pend_tag = mem_read_address[ADDR_WIDTH-1:INDEX_BITS+2];

    assign hit = valid[req_idx] && (tag_mem[req_idx] == req_tag) && !flush;

    // Only word-address bits identify a fill; byte offset is irrelevant.
    assign fill_match = mem_instruction_flag &&
        (mem_instruction_read_address[ADDR_WIDTH-1:2] == mem_read_address[ADDR_WIDTH-1:2]);
    assign unused_fill_lsbs = mem_instruction_read_address[1:0];

    // A flush seen anywhere in the miss, including on the accept edge itself,
    // must keep the returning word out of the arrays.
    assign install = (state == MISS) && fill_match && !drop && !flush;

    always_ff @(posedge clk) begin
        if (install) begin
            tag_mem[pend_idx]  <= pend_tag;
            data_mem[pend_idx] <= mem_instruction;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                     <= IDLE;
            valid                     <= '0;
            drop                      <= 1'b0;
            _instruction_flag         <= 1'b0;
            _instruction_read_address <= '0;
            _instruction              <= '0;
            _busy                     <= 1'b0;
            mem_read_flag             <= 1'b0;
            mem_read_address          <= '0;
        end else begin
            _instruction_flag <= 1'b0;

            if (flush) begin
                valid <= '0;
            end else if (install) begin
                valid[pend_idx] <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (if_read_flag) begin
                        if (hit) begin
                            _instruction_flag         <= 1'b1;
                            _instruction              <= data_mem[req_idx];
                            _instruction_read_address <= if_read_address;
                        end else begin
                            mem_read_address <= {if_read_address[ADDR_WIDTH-1:2], 2'b00};
                            mem_read_flag    <= 1'b1;
                            _busy            <= 1'b1;
                            drop             <= 1'b0;
                            state            <= MISS;
                        end
                    end
                end
                MISS: begin
                    if (flush) begin
                        drop <= 1'b1;
                    end
                    if (fill_match) begin
                        _instruction_flag         <= 1'b1;
                        _instruction              <= mem_instruction;
                        _instruction_read_address <= mem_read_address;
                        mem_read_flag             <= 1'b0;
                        _busy                     <= 1'b0;
                        drop                      <= 1'b0;
                        state                     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - scoreboard testbench for icache_direct
module tb_icache_direct;
    logic        clk;
    logic        rst;
    logic        if_read_flag;
    logic [31:0] if_read_address;
    logic        flush;
    logic        _instruction_flag;
    logic [31:0] _instruction_read_address;
    logic [31:0] _instruction;
    logic        _busy;
    logic        mem_read_flag;
    logic [31:0] mem_read_address;
    logic        mem_instruction_flag;
    logic [31:0] mem_instruction_read_address;
    logic [31:0] mem_instruction;

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] exp_e;

    icache_direct #(.INDEX_BITS(6), .ADDR_WIDTH(32)) dut (
        .clk                          (clk),
        .rst                          (rst),
        .if_read_flag                 (if_read_flag),
        .if_read_address              (if_read_address),
        .flush                        (flush),
        ._instruction_flag            (_instruction_flag),
        ._instruction_read_address    (_instruction_read_address),
        ._instruction                 (_instruction),
        ._busy                        (_busy),
        .mem_read_flag                (mem_read_flag),
        .mem_read_address             (mem_read_address),
        .mem_instruction_flag         (mem_instruction_flag),
        .mem_instruction_read_address (mem_instruction_read_address),
        .mem_instruction              (mem_instruction)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: every response pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (_instruction_flag) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_response addr=%h data=%h required=no response",
                         _instruction_read_address, _instruction);
            end else begin
                exp_e = exp_q.pop_front();
                if ({_instruction_read_address, _instruction} !== exp_e) begin
                    n_errors++;
                    $display("FAIL response addr/data=%h/%h required=%h/%h",
                             _instruction_read_address, _instruction, exp_e[63:32], exp_e[31:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [31:0] addr, input logic [31:0] word);
        mem_instruction_flag         = 1'b1;
        mem_instruction_read_address = addr;
        mem_instruction              = word;
        tick();
        mem_instruction_flag         = 1'b0;
    endtask

    task automatic request(input logic [31:0] addr, input logic fl);
        if_read_flag    = 1'b1;
        if_read_address = addr;
        flush           = fl;
        tick();
        if_read_flag    = 1'b0;
        flush           = 1'b0;
    endtask

    task automatic do_miss(input string name, input logic [31:0] addr,
                           input logic [31:0] word, input logic fl);
        exp_q.push_back({addr, word});
        request(addr, fl);
        chk({name, "_mem_read_flag"}, 32'(mem_read_flag), 32'd1);
        chk({name, "_mem_read_address"}, mem_read_address, addr);
        chk({name, "_busy"}, 32'(_busy), 32'd1);
        fill(addr, word);
        chk({name, "_mem_read_flag_after"}, 32'(mem_read_flag), 32'd0);
        chk({name, "_busy_after"}, 32'(_busy), 32'd0);
        chk({name, "_flag_after"}, 32'(_instruction_flag), 32'd1);
    endtask

    task automatic do_hit(input string name, input logic [31:0] addr, input logic [31:0] word);
        exp_q.push_back({addr, word});
        request(addr, 1'b0);
        chk({name, "_flag"}, 32'(_instruction_flag), 32'd1);
        chk({name, "_no_mem_read"}, 32'(mem_read_flag), 32'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        chk({name, "_flag"}, 32'(_instruction_flag), 32'd0);
        chk({name, "_addr"}, _instruction_read_address, 32'd0);
        chk({name, "_instr"}, _instruction, 32'd0);
        chk({name, "_busy"}, 32'(_busy), 32'd0);
        chk({name, "_mem_flag"}, 32'(mem_read_flag), 32'd0);
        chk({name, "_mem_addr"}, mem_read_address, 32'd0);
    endtask

    logic [31:0] hit_addr [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] hit_word [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};

    initial begin
        rst = 1'b1;
        if_read_flag = 1'b0;
        if_read_address = '0;
        flush = 1'b0;
        mem_instruction_flag = 1'b0;
        mem_instruction_read_address = '0;
        mem_instruction = '0;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // 1: cold miss at 0x0
        do_miss("t1", 32'h0, 32'h00000013, 1'b0);

        // 2: single hit, then preload and four back-to-back hits
        do_hit("t2_hit0", 32'h0, 32'h00000013);
        for (int i = 1; i < 4; i++) do_miss("t2_pre", hit_addr[i], hit_word[i], 1'b0);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({hit_addr[i], hit_word[i]});
            if_read_flag    = 1'b1;
            if_read_address = hit_addr[i];
            tick();
            chk("t2_b2b_flag", 32'(_instruction_flag), 32'd1);
            chk("t2_b2b_no_mem", 32'(mem_read_flag), 32'd0);
        end
        if_read_flag = 1'b0;
        tick();

        // 3: aliasing between 0x100 and 0x0
        do_miss("t3_fill100", 32'h100, 32'hAAAA0100, 1'b0);
        do_miss("t3_miss0", 32'h0, 32'h00000013, 1'b0);
        do_miss("t3_miss100", 32'h100, 32'hAAAA0100, 1'b0);

        // 4: mismatched fill ignored
        exp_q.push_back({32'h20, 32'h20202020});
        request(32'h20, 1'b0);
        chk("t4_mem_addr", mem_read_address, 32'h20);
        fill(32'h24, 32'h24242424);
        chk("t4_still_busy", 32'(_busy), 32'd1);
        chk("t4_no_resp", 32'(_instruction_flag), 32'd0);
        chk("t4_mem_flag_held", 32'(mem_read_flag), 32'd1);
        fill(32'h20, 32'h20202020);
        chk("t4_done_flag", 32'(_instruction_flag), 32'd1);
        chk("t4_done_busy", 32'(_busy), 32'd0);

        // request with flush in the same cycle misses, but its fill is still installed
        do_miss("t45_pre0", 32'h0, 32'h00000013, 1'b0);
        do_hit("t45_hit0", 32'h0, 32'h00000013);
        do_miss("t45_flushreq", 32'h0, 32'h00000013, 1'b1);
        do_hit("t45_hit0_again", 32'h0, 32'h00000013);

        // 5: flush during MISS for 0x40
        exp_q.push_back({32'h40, 32'h40404040});
        request(32'h40, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t5_busy", 32'(_busy), 32'd1);
        fill(32'h40, 32'h40404040);
        chk("t5_resp", 32'(_instruction_flag), 32'd1);
        do_miss("t5_miss40", 32'h40, 32'h40404040, 1'b0);
        do_miss("t5_miss0", 32'h0, 32'h00000013, 1'b0);

        // 6: reset mid-miss abandons the miss
        request(32'h80, 1'b0);
        chk("t6_busy", 32'(_busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_outputs_zero("t6_after_rst");
        fill(32'h80, 32'h80808080);
        chk("t6_fill_ignored", 32'(_instruction_flag), 32'd0);
        chk("t6_busy_after_fill", 32'(_busy), 32'd0);
        do_miss("t6_miss0", 32'h0, 32'h00000013, 1'b0);

        repeat (2) tick();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
